// File: rtl/mc_maindec_if.sv
// Control bundle between the multicycle main decoder and the datapath/memory.
// master = decoder side, slave = datapath side.
interface mc_maindec_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       we_dm;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       branch;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       we_reg;
    logic       mem2reg;
    logic       jal;
    logic       mul_start;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, mem_ready,
        output mem_req, iord, we_dm, ir_we, pc_we, pc_src, branch, alu_src_a,
               alu_src_b, alu_op, reg_dst, we_reg, mem2reg, jal, mul_start,
               illegal, state
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  mem_req, iord, we_dm, ir_we, pc_we, pc_src, branch, alu_src_a,
               alu_src_b, alu_op, reg_dst, we_reg, mem2reg, jal, mul_start,
               illegal, state
    );
endinterface

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: FETCH/DECODE/EXEC/MEM/WB, 3-5 cycles per instruction (MULTU: 2+MUL_CYCLES).
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; reset clears outputs asynchronously.
module mc_maindec #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic          clk,
    input  logic          rst,
    mc_maindec_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEX    = 4'd6,
        S_RTWB    = 4'd7,
        S_ADDIEX  = 4'd8,
        S_ADDIWB  = 4'd9,
        S_BEQ     = 4'd10,
        S_JUMP    = 4'd11,
        S_MULEX   = 4'd12,
        S_ILLEGAL = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_MULTU = 6'b011001;

    state_t           st;
    state_t           st_nxt;
    logic [CNT_W-1:0] cnt;
    logic             illegal_q;
    logic             is_multu;

    assign is_multu = (bus.opcode == OP_RTYPE) && (bus.funct == FN_MULTU);

    always_comb begin
        st_nxt = st;
        case (st)
            S_FETCH:   if (bus.mem_ready) st_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      st_nxt = is_multu ? S_MULEX : S_RTEX;
                    OP_ADDI:       st_nxt = S_ADDIEX;
                    OP_BEQ:        st_nxt = S_BEQ;
                    OP_J, OP_JAL:  st_nxt = S_JUMP;
                    OP_LW, OP_SW:  st_nxt = S_MEMADR;
                    default:       st_nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  st_nxt = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (bus.mem_ready) st_nxt = S_MEMWB;
            S_MEMWB:   st_nxt = S_FETCH;
            S_MEMWR:   if (bus.mem_ready) st_nxt = S_FETCH;
            S_RTEX:    st_nxt = S_RTWB;
            S_RTWB:    st_nxt = S_FETCH;
            S_ADDIEX:  st_nxt = S_ADDIWB;
            S_ADDIWB:  st_nxt = S_FETCH;
            S_BEQ:     st_nxt = S_FETCH;
            S_JUMP:    st_nxt = S_FETCH;
            S_MULEX:   if (cnt == '0) st_nxt = S_FETCH;
            S_ILLEGAL: st_nxt = S_ILLEGAL;
            // encodings 13/14 are unreachable in normal operation; trap them
            default:   st_nxt = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_FETCH;
            cnt       <= '0;
            illegal_q <= 1'b0;
        end else begin
            st <= st_nxt;
            if (st == S_DECODE && is_multu)
                cnt <= CNT_W'(MUL_CYCLES - 1);
            else if (st == S_MULEX && cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (st_nxt == S_ILLEGAL)
                illegal_q <= 1'b1;
        end
    end

    // Decoded from the state register; forced low while rst is high so a
    // pending memory request drops without waiting for a clock.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.iord      = 1'b0;
        bus.we_dm     = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_src    = 2'b00;
        bus.branch    = 1'b0;
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'b00;
        bus.alu_op    = 2'b00;
        bus.reg_dst   = 1'b0;
        bus.we_reg    = 1'b0;
        bus.mem2reg   = 1'b0;
        bus.jal       = 1'b0;
        bus.mul_start = 1'b0;
        if (!rst) begin
            case (st)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_we     = bus.mem_ready;
                    bus.pc_we     = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b = 2'b11;
                    bus.mul_start = is_multu;
                end
                S_MEMADR, S_ADDIEX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_MEMWB: begin
                    bus.we_reg  = 1'b1;
                    bus.mem2reg = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    bus.we_dm   = 1'b1;
                end
                S_RTEX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                end
                S_RTWB: begin
                    bus.we_reg  = 1'b1;
                    bus.reg_dst = 1'b1;
                end
                S_ADDIWB: bus.we_reg = 1'b1;
                S_BEQ: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b01;
                    bus.branch    = 1'b1;
                    bus.pc_src    = 2'b01;
                end
                S_JUMP: begin
                    bus.pc_we  = 1'b1;
                    bus.pc_src = 2'b10;
                    bus.jal    = (bus.opcode == OP_JAL);
                    bus.we_reg = (bus.opcode == OP_JAL);
                end
                default: ;
            endcase
        end
    end

    assign bus.state   = st;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_mc_maindec.sv
// Directed bench for mc_maindec: two instances (MUL_CYCLES=4 and 1) share stimulus.
module tb_mc_maindec;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       mem_ready = 1'b0;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    mc_maindec_if ia();
    mc_maindec_if ib();
    assign ia.opcode = opcode;
    assign ia.funct = funct;
    assign ia.mem_ready = mem_ready;
    assign ib.opcode = opcode;
    assign ib.funct = funct;
    assign ib.mem_ready = mem_ready;

    mc_maindec #(.MUL_CYCLES(4), .CNT_W(3)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
    mc_maindec #(.MUL_CYCLES(1), .CNT_W(1)) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input logic rdy);
        mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("rst_state", ia.state, 0);
        chk("rst_mem_req", ia.mem_req, 0);
        chk("rst_pc_we", ia.pc_we, 0);
        chk("rst_alu_src_b", ia.alu_src_b, 0);
        chk("rst_illegal", ia.illegal, 0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        // ---------------- LW, memory always ready ----------------
        begin : lw_blk
            int exp_st [6] = '{0, 1, 2, 3, 4, 0};
            int pcw = 0, wr = 0;
            do_reset;
            opcode = 6'h23; funct = 6'h00;
            for (int i = 0; i < 6; i++) begin
                cyc(1'b1);
                chk("lw_state", ia.state, exp_st[i]);
                if (i == 0) chk("lw_fetch_ir_we", ia.ir_we, 1);
                if (i < 5) begin
                    pcw += int'(ia.pc_we);
                    wr  += int'(ia.we_reg);
                    if (ia.we_reg) chk("lw_wb_mem2reg", {ia.state, ia.mem2reg}, {4'd4, 1'b1});
                end
                tick;
            end
            chk("lw_pc_we_cycles", pcw, 1);
            chk("lw_we_reg_cycles", wr, 1);
        end

        // ---------------- SW, 3 wait cycles in MEMWR ----------------
        begin : sw_blk
            int    exp_st [8] = '{0, 1, 2, 5, 5, 5, 5, 0};
            logic  rdy [8]    = '{1, 0, 0, 0, 0, 0, 1, 0};
            int    held = 0, pcw = 0;
            do_reset;
            opcode = 6'h2b;
            for (int i = 0; i < 8; i++) begin
                cyc(rdy[i]);
                chk("sw_state", ia.state, exp_st[i]);
                if (ia.mem_req && ia.we_dm && ia.iord) held++;
                if (i >= 3 && i <= 6) pcw += int'(ia.pc_we);
                tick;
            end
            chk("sw_write_held", held, 4);
            chk("sw_pc_we_in_memwr", pcw, 0);
        end

        // ---------------- MULTU, MUL_CYCLES=4 (A) and 1 (B) ----------------
        begin : mul_blk
            int exp_a [7] = '{0, 1, 12, 12, 12, 12, 0};
            int exp_b [7] = '{0, 1, 12, 0, 0, 0, 0};
            int ms_a = 0, ms_b = 0, wr = 0, mx_a = 0, mx_b = 0;
            do_reset;
            opcode = 6'h00; funct = 6'h19;
            for (int i = 0; i < 7; i++) begin
                cyc(i == 0);
                chk("mul_a_state", ia.state, exp_a[i]);
                chk("mul_b_state", ib.state, exp_b[i]);
                if (i == 1) chk("mul_start_at_decode", ia.mul_start, 1);
                ms_a += int'(ia.mul_start);
                ms_b += int'(ib.mul_start);
                wr   += int'(ia.we_reg) + int'(ib.we_reg);
                if (ia.state == 4'd12) mx_a++;
                if (ib.state == 4'd12) mx_b++;
                tick;
            end
            chk("mul_a_start_pulses", ms_a, 1);
            chk("mul_b_start_pulses", ms_b, 1);
            chk("mul_we_reg", wr, 0);
            chk("mul_a_mulex_cycles", mx_a, 4);
            chk("mul_b_mulex_cycles", mx_b, 1);
        end

        // ---------------- JAL then J ----------------
        for (int k = 0; k < 2; k++) begin : jmp_blk
            int exp_st [4] = '{0, 1, 11, 0};
            logic is_jal;
            is_jal = (k == 0);
            do_reset;
            opcode = is_jal ? 6'h03 : 6'h02;
            for (int i = 0; i < 4; i++) begin
                cyc(i == 0);
                chk("jmp_state", ia.state, exp_st[i]);
                if (i == 2) begin
                    chk("jmp_pc_we", ia.pc_we, 1);
                    chk("jmp_pc_src", ia.pc_src, 2);
                    chk("jmp_jal", ia.jal, is_jal);
                    chk("jmp_we_reg", ia.we_reg, is_jal);
                end
                tick;
            end
        end

        // ---------------- R-type ADD (mem_ready ignored mid-instruction) ----------------
        begin : rt_blk
            int exp_st [5] = '{0, 1, 6, 7, 0};
            do_reset;
            opcode = 6'h00; funct = 6'h20;
            for (int i = 0; i < 5; i++) begin
                cyc(i < 4);
                chk("rt_state", ia.state, exp_st[i]);
                if (i == 2) chk("rt_ex_ctrl", {ia.alu_src_a, ia.alu_src_b, ia.alu_op}, 5'b1_00_10);
                if (i == 3) chk("rt_wb_ctrl", {ia.we_reg, ia.reg_dst, ia.mem2reg}, 3'b110);
                tick;
            end
        end

        // ---------------- BEQ ----------------
        begin : beq_blk
            int exp_st [4] = '{0, 1, 10, 0};
            do_reset;
            opcode = 6'h04; funct = 6'h00;
            for (int i = 0; i < 4; i++) begin
                cyc(i == 0);
                chk("beq_state", ia.state, exp_st[i]);
                if (i == 1) chk("beq_decode_alu_src_b", ia.alu_src_b, 3);
                if (i == 2) chk("beq_ctrl", {ia.branch, ia.pc_src, ia.alu_op, ia.alu_src_a, ia.pc_we},
                                7'b1_01_01_1_0);
                tick;
            end
        end

        // ---------------- Illegal opcode, sticky until reset ----------------
        begin : ill_blk
            int good = 0;
            do_reset;
            opcode = 6'h3f;
            cyc(1'b1); tick;
            cyc(1'b0);
            chk("ill_decode_state", ia.state, 1);
            tick;
            for (int i = 0; i < 20; i++) begin
                cyc(1'b1);
                if (ia.illegal && ia.state == 4'd15 && !ia.pc_we && !ia.mem_req && !ia.we_reg) good++;
                tick;
            end
            chk("ill_held_cycles", good, 20);
            do_reset;
            cyc(1'b0);
            chk("ill_after_rst_state", ia.state, 0);
            chk("ill_after_rst_flag", ia.illegal, 0);
        end

        // ---------------- Asynchronous reset while MEMRD is waiting ----------------
        begin : arst_blk
            do_reset;
            opcode = 6'h23;
            cyc(1'b1); tick;
            cyc(1'b0); tick;
            cyc(1'b0); tick;
            cyc(1'b0);
            chk("arst_memrd_state", ia.state, 3);
            chk("arst_memrd_req", {ia.mem_req, ia.iord}, 2'b11);
            #2;
            rst = 1'b1;
            #1;
            chk("arst_req_dropped", ia.mem_req, 0);
            chk("arst_state_now", ia.state, 0);
            chk("arst_no_wb", ia.we_reg, 0);
            tick;
            rst = 1'b0;
            cyc(1'b0);
            chk("arst_release_state", ia.state, 0);
            chk("arst_release_req", ia.mem_req, 1);
            tick;
            cyc(1'b0);
            chk("arst_fetch_stall", ia.state, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
